counter_sequencer: RTL and testbench

//   Upstream controller for the counter block. It turns one go request into N back-to-back

---
 rtl/counter_sequencer.sv | 166 ++++++++++++++++
 tb/tb_counter_sequencer.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer
//   Upstream controller for the counter block. One accepted go request becomes
//   N back-to-back counter runs: pulse counter start, wait for enabled, wait for
//   a qualified done, insert an idle gap, repeat. Reports progress (run_index),
//   completion (finished) and a stalled counter (timeout).
//
// Ports
//   clock_i            system clock, rising edge
//   reset_i            synchronous, active-high
//   go_i               request; only looked at in IDLE (level or pulse)
//   runs_i             run count, captured when go is accepted
//   counter_done_i     counter done
//   counter_enabled_i  counter enabled
//   counter_start_o    counter start, one-cycle pulse
//   busy_o             high from go acceptance until return to IDLE
//   run_index_o        completed runs in the current request
//   finished_o         one-cycle pulse, all runs completed
//   timeout_o          one-cycle pulse, watchdog abort
module counter_sequencer #(
  parameter int RUN_WIDTH      = 4,
  parameter int GAP_CYCLES     = 2,
  parameter int TIMEOUT_CYCLES = 1024,
  parameter int TIMER_WIDTH    = 11
) (
  input  logic                 clock_i,
  input  logic                 reset_i,
  input  logic                 go_i,
  input  logic [RUN_WIDTH-1:0] runs_i,
  input  logic                 counter_done_i,
  input  logic                 counter_enabled_i,
  output logic                 counter_start_o,
  output logic                 busy_o,
  output logic [RUN_WIDTH-1:0] run_index_o,
  output logic                 finished_o,
  output logic                 timeout_o
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LAUNCH,
    S_WAIT_EN,
    S_WAIT_DONE,
    S_GAP,
    S_FINISH
  } state_e;

  // A zero gap still leaves one cycle with start low so the counter can clear done.
  localparam int                     GAP_EFF  = (GAP_CYCLES < 1) ? 1 : GAP_CYCLES;
  localparam logic [TIMER_WIDTH-1:0] GAP_LAST = TIMER_WIDTH'(GAP_EFF - 1);
  localparam bit                     WDOG_EN  = (TIMEOUT_CYCLES > 0);
  localparam logic [TIMER_WIDTH-1:0] TO_LAST  =
    TIMER_WIDTH'(WDOG_EN ? TIMEOUT_CYCLES - 1 : 0);

  state_e                 state_q;
  logic [RUN_WIDTH-1:0]   runs_q;
  logic [RUN_WIDTH-1:0]   run_index_q;
  logic [TIMER_WIDTH-1:0] timer_q;
  logic                   start_q;
  logic                   busy_q;
  logic                   finished_q;
  logic                   timeout_q;

  logic [RUN_WIDTH-1:0]   idx_d;
  logic [TIMER_WIDTH-1:0] timer_d;
  logic                   done_ok;
  logic                   timer_exp;

  // done may still be high from the previous run while the new run is enabled,
  // so completion needs enabled to have dropped as well.
  assign done_ok   = counter_done_i && !counter_enabled_i;
  assign idx_d     = run_index_q + RUN_WIDTH'(1);
  // Saturating increment: the timer never wraps.
  assign timer_d   = (timer_q == {TIMER_WIDTH{1'b1}}) ? timer_q : timer_q + TIMER_WIDTH'(1);
  assign timer_exp = WDOG_EN && (timer_q == TO_LAST);

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      state_q     <= S_IDLE;
      runs_q      <= '0;
      run_index_q <= '0;
      timer_q     <= '0;
      start_q     <= 1'b0;
      busy_q      <= 1'b0;
      finished_q  <= 1'b0;
      timeout_q   <= 1'b0;
    end else begin
      // Pulse outputs default low every cycle.
      start_q    <= 1'b0;
      finished_q <= 1'b0;
      timeout_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (go_i) begin
            if (runs_i != '0) begin
              runs_q      <= runs_i;
              run_index_q <= '0;
              busy_q      <= 1'b1;
              start_q     <= 1'b1;
              state_q     <= S_LAUNCH;
            end else begin
              finished_q <= 1'b1;
            end
          end
        end
        S_LAUNCH: begin
          timer_q <= '0;
          state_q <= S_WAIT_EN;
        end
        S_WAIT_EN: begin
          // Exit is tested before expiry so it wins a same-cycle tie.
          if (counter_enabled_i) begin
            timer_q <= '0;
            state_q <= S_WAIT_DONE;
          end else if (timer_exp) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_WAIT_DONE: begin
          if (done_ok) begin
            run_index_q <= idx_d;
            if (idx_d == runs_q) begin
              finished_q <= 1'b1;
              state_q    <= S_FINISH;
            end else begin
              timer_q <= '0;
              state_q <= S_GAP;
            end
          end else if (timer_exp) begin
            timeout_q <= 1'b1;
            busy_q    <= 1'b0;
            state_q   <= S_IDLE;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_GAP: begin
          if (timer_q >= GAP_LAST) begin
            start_q <= 1'b1;
            state_q <= S_LAUNCH;
          end else begin
            timer_q <= timer_d;
          end
        end
        S_FINISH: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign counter_start_o = start_q;
  assign busy_o          = busy_q;
  assign run_index_o     = run_index_q;
  assign finished_o      = finished_q;
  assign timeout_o       = timeout_q;

endmodule

// File: tb/tb_counter_sequencer.sv
// Bench for counter_sequencer: drives requests against a small counter model
// (enabled for 5 cycles per run) and scores index/finish/timeout events.
module tb_counter_sequencer;

  localparam int RW = 4;
  localparam int K_IDX = 0, K_FIN = 1, K_TMO = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          go;
  logic [RW-1:0] runs;
  logic          counter_start, busy, finished, timeout;
  logic [RW-1:0] run_index;

  // counter model
  logic m_en, m_done;
  int   m_cnt;
  bit   no_enable, hold_done;

  int n_chk = 0, n_err = 0;
  int start_cnt = 0, busy_cnt = 0, cyc = 0;
  int done_cyc = -1, prev_idx = 0;
  bit prev_en = 0, prev_done = 0, gap_chk_en = 0;

  typedef struct { int kind; int val; } ev_t;
  ev_t sb_q[$];

  always #5 clk = ~clk;

  counter_sequencer #(
    .RUN_WIDTH(RW), .GAP_CYCLES(2), .TIMEOUT_CYCLES(16), .TIMER_WIDTH(5)
  ) dut (
    .clock_i(clk), .reset_i(reset), .go_i(go), .runs_i(runs),
    .counter_done_i(m_done), .counter_enabled_i(m_en),
    .counter_start_o(counter_start), .busy_o(busy), .run_index_o(run_index),
    .finished_o(finished), .timeout_o(timeout)
  );

  always @(posedge clk) begin
    if (reset) begin
      m_en <= 1'b0; m_done <= 1'b0; m_cnt <= 0;
    end else if (m_en) begin
      if (m_cnt == 4) begin m_en <= 1'b0; m_done <= 1'b1; end
      else m_cnt <= m_cnt + 1;
    end else if (counter_start && !no_enable) begin
      m_en <= 1'b1; m_cnt <= 0;
    end else if (!counter_start && !hold_done) begin
      m_done <= 1'b0;
    end
  end

  task automatic chk(input string tag, input int got, input int exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k; e.val = v;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int k, input int v);
    ev_t e;
    if (sb_q.size() == 0) chk("sb_unexp", k, -1);
    else begin
      e = sb_q.pop_front();
      chk("sb_kind", k, e.kind);
      chk("sb_val", v, e.val);
    end
  endtask

  // Monitor: samples on the falling edge, away from the DUT's active edge.
  always @(negedge clk) begin
    cyc++;
    if (reset) begin
      prev_idx = 0; done_cyc = -1;
    end else begin
      if (busy) busy_cnt++;
      if (counter_start) begin
        start_cnt++;
        if (gap_chk_en && done_cyc >= 0) chk("gap", cyc - done_cyc, 3);
        done_cyc = -1;
      end
      if (gap_chk_en && busy && m_done && !m_en && done_cyc < 0) done_cyc = cyc;
      if (int'(run_index) != prev_idx && run_index != '0) begin
        chk("idx_qual", int'(prev_done && !prev_en), 1);
        sb_pop(K_IDX, int'(run_index));
      end
      if (finished || timeout) begin
        chk("fin_tmo_excl", int'(finished && timeout), 0);
        if (finished) sb_pop(K_FIN, int'(run_index));
        if (timeout)  sb_pop(K_TMO, int'(run_index));
        done_cyc = -1;
      end
      prev_idx = int'(run_index);
    end
    prev_en = m_en; prev_done = m_done;
  end

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 300; i++) begin
      step();
      if (!busy) break;
    end
    chk(tag, int'(busy), 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_start"}, int'(counter_start), 0);
    chk({tag, "_busy"},  int'(busy), 0);
    chk({tag, "_idx"},   int'(run_index), 0);
    chk({tag, "_fin"},   int'(finished), 0);
    chk({tag, "_tmo"},   int'(timeout), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout busy=%0d", busy);
    $fatal(1, "bench time limit");
  end

  initial begin
    int s0, s1, b0, lat;
    bit hit;
    reset = 1'b1; go = 1'b0; runs = '0;
    no_enable = 0; hold_done = 0;
    repeat (3) step();
    chk_zero("rst");
    reset = 1'b0;
    step();

    // runs=0: finished one cycle later, no start, busy stays low
    s0 = start_cnt; b0 = busy_cnt;
    push(K_FIN, 0);
    go = 1'b1; runs = 4'd0;
    step();
    chk("r0_fin", int'(finished), 1);
    go = 1'b0;
    step();
    chk("r0_fin_off", int'(finished), 0);
    repeat (3) step();
    chk("r0_nostart", start_cnt - s0, 0);
    chk("r0_busy", busy_cnt - b0, 0);

    // runs=3 normal sequence; runs changes while busy are ignored
    gap_chk_en = 1;
    s0 = start_cnt;
    push(K_IDX, 1); push(K_IDX, 2); push(K_IDX, 3); push(K_FIN, 3);
    go = 1'b1; runs = 4'd3;
    step();
    go = 1'b0; runs = 4'd7;
    chk("t1_busy", int'(busy), 1);
    chk("t1_start_lat", int'(counter_start), 1);
    wait_idle("t1_done");
    chk("t1_starts", start_cnt - s0, 3);
    chk("t1_idx", int'(run_index), 3);
    gap_chk_en = 0;
    step();

    // counter never enables: watchdog abort 16 cycles into WAIT_EN
    no_enable = 1;
    s0 = start_cnt; lat = -1;
    push(K_TMO, 0);
    go = 1'b1; runs = 4'd2;
    step();
    go = 1'b0;
    for (int i = 0; i < 100; i++) begin
      step();
      if (timeout) begin lat = i + 1; break; end
    end
    chk("t3_lat", lat, 17);
    chk("t3_busy", int'(busy), 0);
    chk("t3_idx", int'(run_index), 0);
    chk("t3_starts", start_cnt - s0, 1);
    no_enable = 0;
    repeat (3) step();

    // go held high: second request starts only after FINISH
    s0 = start_cnt; hit = 0;
    repeat (2) begin push(K_IDX, 1); push(K_IDX, 2); push(K_FIN, 2); end
    go = 1'b1; runs = 4'd2;
    for (int i = 0; i < 200; i++) begin
      step();
      if (finished) begin hit = 1; break; end
    end
    chk("t4_fin_seen", int'(hit), 1);
    chk("t4_starts_a", start_cnt - s0, 2);
    chk("t4_busy_fin", int'(busy), 1);
    step();
    chk("t4_idle_busy", int'(busy), 0);
    chk("t4_idle_start", int'(counter_start), 0);
    step();
    chk("t4_relaunch_busy", int'(busy), 1);
    chk("t4_relaunch_start", int'(counter_start), 1);
    repeat (4) step();
    go = 1'b0;
    wait_idle("t4_done");
    chk("t4_starts", start_cnt - s0, 4);
    step();

    // reset while in WAIT_DONE of run 2 of 4
    push(K_IDX, 1);
    hit = 0;
    go = 1'b1; runs = 4'd4;
    step();
    go = 1'b0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (run_index == 4'd1 && m_en && m_cnt == 2) begin hit = 1; break; end
    end
    chk("t5_reached", int'(hit), 1);
    reset = 1'b1;
    step();
    chk_zero("t5_rst");
    reset = 1'b0;
    s1 = start_cnt;
    repeat (20) step();
    chk("t5_nostart", start_cnt - s1, 0);

    // done stuck high into the next run: completion waits for enabled to fall
    hold_done = 1;
    s0 = start_cnt;
    push(K_IDX, 1); push(K_IDX, 2); push(K_FIN, 2);
    go = 1'b1; runs = 4'd2;
    step();
    go = 1'b0;
    wait_idle("t6_done");
    chk("t6_idx", int'(run_index), 2);
    chk("t6_starts", start_cnt - s0, 2);
    hold_done = 0;
    repeat (3) step();

    chk("sb_left", sb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
